// File: rtl/pc_seq_pkg.sv
// Shared encodings for the program-counter sequencer.
// Next-PC select codes; unlisted codes fall back to sequential.
package pc_seq_pkg;

  localparam int SEL_W = 3;

  localparam logic [SEL_W-1:0] SEL_SEQ    = 3'd0;
  localparam logic [SEL_W-1:0] SEL_BRANCH = 3'd1;
  localparam logic [SEL_W-1:0] SEL_JUMP   = 3'd2;
  localparam logic [SEL_W-1:0] SEL_CALL   = 3'd3;
  localparam logic [SEL_W-1:0] SEL_RET    = 3'd4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full
// overwrites the oldest entry and sets a sticky flag.
module pc_ras #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4,
  localparam int PW = $clog2(RAS_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             ovf,
  output logic             unf
);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    top_idx;
  logic             full;
  logic             empty;

  // ptr is the next free slot, so the top lives one below it
  assign top_idx = ptr - PW'(1);
  assign top     = mem[top_idx];
  assign full    = (count == CW'(RAS_DEPTH));
  assign empty   = (count == '0);

  always_ff @(posedge clock) begin
    if (push) mem[ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      unf <= 1'b0;
      if (push) begin
        ptr <= ptr + PW'(1);
        if (!full) count <= count + CW'(1);
        else       ovf   <= 1'b1;
      end else if (pop) begin
        if (!empty) begin
          ptr   <= top_idx;
          count <= count - CW'(1);
        end else begin
          unf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register with next-PC select and
// a return-address stack for call/return.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               STEP      = 1,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int               RAS_DEPTH = 4,
  localparam int CW = $clog2(RAS_DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic [SEL_W-1:0] sel,
  input  logic             cond,
  input  logic [WIDTH-1:0] offset,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_seq,
  output logic [CW-1:0]    ras_count,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_unf
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] ras_top;
  logic             push;
  logic             pop;

  assign pc_seq    = pc + STEP_W;
  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == CW'(RAS_DEPTH));

  always_comb begin
    pc_next = pc_seq;
    push    = 1'b0;
    pop     = 1'b0;
    case (sel)
      SEL_BRANCH: if (cond) pc_next = pc + offset;
      SEL_JUMP:   pc_next = target;
      SEL_CALL: begin
        pc_next = target;
        push    = 1'b1;
      end
      SEL_RET: begin
        pop = 1'b1;
        if (!ras_empty) pc_next = ras_top;
      end
      default: pc_next = pc_seq;
    endcase
    // a stalled cycle must leave the stack untouched
    if (stall) begin
      push = 1'b0;
      pop  = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       pc <= RESET_PC;
    else if (!stall) pc <= pc_next;
  end

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_seq),
    .top       (ras_top),
    .count     (ras_count),
    .ovf       (ras_ovf),
    .unf       (ras_unf)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with an expected-result
// queue; also covers a 16-bit, STEP=4 instance.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [2:0]  cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sbq[$];
  int compared   = 0;
  int mismatched = 0;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             stall = 1'b0;
  logic [SEL_W-1:0] sel   = SEL_SEQ;
  logic             cond  = 1'b0;
  logic [31:0]      offset = '0;
  logic [31:0]      target = '0;
  logic [31:0]      pc;
  logic [31:0]      pc_seq;
  logic [2:0]       ras_count;
  logic             ras_empty, ras_full, ras_ovf, ras_unf;

  logic             reset16 = 1'b1;
  logic             stall16 = 1'b0;
  logic [SEL_W-1:0] sel16   = SEL_SEQ;
  logic [15:0]      pc16;
  logic [15:0]      pc_seq16;
  logic [2:0]       cnt16;
  logic             empty16, full16, ovf16, unf16;

  always #5 clock = ~clock;

  pc_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .stall     (stall),
    .sel       (sel),
    .cond      (cond),
    .offset    (offset),
    .target    (target),
    .pc        (pc),
    .pc_seq    (pc_seq),
    .ras_count (ras_count),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf)
  );

  pc_sequencer #(
    .WIDTH    (16),
    .STEP     (4),
    .RESET_PC (16'h0100)
  ) dut16 (
    .clock     (clock),
    .reset     (reset16),
    .stall     (stall16),
    .sel       (sel16),
    .cond      (1'b0),
    .offset    (16'h0000),
    .target    (16'h0000),
    .pc        (pc16),
    .pc_seq    (pc_seq16),
    .ras_count (cnt16),
    .ras_empty (empty16),
    .ras_full  (full16),
    .ras_ovf   (ovf16),
    .ras_unf   (unf16)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive one cycle, queue its expectation, compare after the edge
  task automatic cyc(input string tag, input logic [2:0] s,
                     input logic c, input logic [31:0] off,
                     input logic [31:0] tgt, input logic st,
                     input logic [31:0] epc, input logic [2:0] ecnt,
                     input logic eovf, input logic eunf);
    exp_t e;
    sel    = s;
    cond   = c;
    offset = off;
    target = tgt;
    stall  = st;
    sbq.push_back('{tag: tag, pc: epc, cnt: ecnt, ovf: eovf, unf: eunf});
    @(posedge clock);
    #1;
    e = sbq.pop_front();
    check({e.tag, ".pc"},  pc,        e.pc);
    check({e.tag, ".cnt"}, 32'(ras_count), 32'(e.cnt));
    check({e.tag, ".ovf"}, 32'(ras_ovf),   32'(e.ovf));
    check({e.tag, ".unf"}, 32'(ras_unf),   32'(e.unf));
  endtask

  initial begin
    // test 1: reset, sequential, stall
    #12;
    check("rst.pc",  pc, 32'd0);
    check("rst.cnt", 32'(ras_count), 32'd0);
    check("rst.ovf", 32'(ras_ovf), 32'd0);
    check("rst.unf", 32'(ras_unf), 32'd0);
    check("rst.empty", 32'(ras_empty), 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("rel.pc", pc, 32'd0);
    for (int i = 1; i <= 5; i++)
      cyc("seq", SEL_SEQ, 0, 0, 0, 0, 32'(i), 0, 0, 0);
    check("pc_seq", pc_seq, 32'd6);
    for (int i = 0; i < 3; i++)
      cyc("stall", SEL_JUMP, 0, 0, 77, 1, 5, 0, 0, 0);

    // test 2: branch and wrap
    cyc("j10",   SEL_JUMP,   0, 0,            10, 0, 10, 0, 0, 0);
    cyc("br_t",  SEL_BRANCH, 1, 32'hFFFFFFFC, 0,  0, 6,  0, 0, 0);
    cyc("br_nt", SEL_BRANCH, 0, 32'hFFFFFFFC, 0,  0, 7,  0, 0, 0);
    cyc("jmax",  SEL_JUMP,   0, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, 0, 0);
    cyc("wrap",  SEL_SEQ,    0, 0,            0,  0, 0,  0, 0, 0);
    cyc("sel7",  3'd7,       1, 32'h40,       99, 0, 1,  0, 0, 0);

    // test 3: nested call/return
    cyc("j2",    SEL_JUMP, 0, 0, 2,   0, 2,   0, 0, 0);
    cyc("call1", SEL_CALL, 0, 0, 100, 0, 100, 1, 0, 0);
    cyc("call2", SEL_CALL, 0, 0, 200, 0, 200, 2, 0, 0);
    cyc("ret1",  SEL_RET,  0, 0, 0,   0, 101, 1, 0, 0);
    cyc("ret2",  SEL_RET,  0, 0, 0,   0, 3,   0, 0, 0);
    check("n.empty", 32'(ras_empty), 32'd1);

    // test 4: overflow
    cyc("j0", SEL_JUMP, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++)
      cyc("ocall", SEL_CALL, 0, 0, 32'(10 * i), 0, 32'(10 * i),
          3'(i), 0, 0);
    check("o.full4", 32'(ras_full), 32'd1);
    cyc("ocall5", SEL_CALL, 0, 0, 50, 0, 50, 4, 1, 0);
    check("o.full5", 32'(ras_full), 32'd1);
    cyc("oret41", SEL_RET, 0, 0, 0, 0, 41, 3, 1, 0);
    cyc("oret31", SEL_RET, 0, 0, 0, 0, 31, 2, 1, 0);
    cyc("oret21", SEL_RET, 0, 0, 0, 0, 21, 1, 1, 0);
    cyc("oret11", SEL_RET, 0, 0, 0, 0, 11, 0, 1, 0);

    // test 5: underflow, stalled RET gives no pulse
    cyc("j50",   SEL_JUMP, 0, 0, 50, 0, 50, 0, 1, 0);
    cyc("uret",  SEL_RET,  0, 0, 0,  0, 51, 0, 1, 1);
    cyc("useq",  SEL_SEQ,  0, 0, 0,  0, 52, 0, 1, 0);
    cyc("ustl",  SEL_RET,  0, 0, 0,  1, 52, 0, 1, 0);

    // back-to-back call then return
    cyc("bcall", SEL_CALL, 0, 0, 300, 0, 300, 1, 1, 0);
    cyc("bret",  SEL_RET,  0, 0, 0,   0, 53,  0, 1, 0);

    // test 6: asynchronous reset mid-operation
    cyc("c60", SEL_CALL, 0, 0, 60, 0, 60, 1, 1, 0);
    cyc("c70", SEL_CALL, 0, 0, 70, 0, 70, 2, 1, 0);
    cyc("c80", SEL_CALL, 0, 0, 80, 0, 80, 3, 1, 0);
    sel = SEL_SEQ;
    #2;
    reset = 1'b1;
    #1;
    check("ar.pc",  pc, 32'd0);
    check("ar.cnt", 32'(ras_count), 32'd0);
    check("ar.ovf", 32'(ras_ovf), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc("ar.seq", SEL_SEQ, 0, 0, 0, 0, 1, 0, 0, 0);

    // 16-bit instance, STEP=4, RESET_PC=0x100
    check("w.rst", 32'(pc16), 32'h100);
    check("w.cnt", 32'(cnt16), 32'd0);
    check("w.flags", {28'd0, empty16, full16, ovf16, unf16}, 32'b1000);
    reset16 = 1'b0;
    @(posedge clock);
    #1;
    check("w.104", 32'(pc16), 32'h104);
    @(posedge clock);
    #1;
    check("w.108", 32'(pc16), 32'h108);
    check("w.seq", 32'(pc_seq16), 32'h10C);
    stall16 = 1'b1;
    @(posedge clock);
    #1;
    check("w.stall", 32'(pc16), 32'h108);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
